// File: rtl/aes192_pkg.sv
// aes192_pkg: shared AES-192 constants, S-box, GF(2^8) helpers and FSM encoding.
package aes192_pkg;
  localparam int NR = 12;
  localparam int NK = 6;
  typedef enum logic [1:0] {IDLE, KEYX, ROUND, OUT} state_e;
  // Entry k holds Rcon[k+1], i.e. the round constant for schedule group k+1.
  localparam logic [7:0] RCON [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] b);
    case (b)
      8'h00: return 8'h63; 8'h01: return 8'h7c; 8'h02: return 8'h77; 8'h03: return 8'h7b; 8'h04: return 8'hf2; 8'h05: return 8'h6b; 8'h06: return 8'h6f; 8'h07: return 8'hc5;
      8'h08: return 8'h30; 8'h09: return 8'h01; 8'h0a: return 8'h67; 8'h0b: return 8'h2b; 8'h0c: return 8'hfe; 8'h0d: return 8'hd7; 8'h0e: return 8'hab; 8'h0f: return 8'h76;
      8'h10: return 8'hca; 8'h11: return 8'h82; 8'h12: return 8'hc9; 8'h13: return 8'h7d; 8'h14: return 8'hfa; 8'h15: return 8'h59; 8'h16: return 8'h47; 8'h17: return 8'hf0;
      8'h18: return 8'had; 8'h19: return 8'hd4; 8'h1a: return 8'ha2; 8'h1b: return 8'haf; 8'h1c: return 8'h9c; 8'h1d: return 8'ha4; 8'h1e: return 8'h72; 8'h1f: return 8'hc0;
      8'h20: return 8'hb7; 8'h21: return 8'hfd; 8'h22: return 8'h93; 8'h23: return 8'h26; 8'h24: return 8'h36; 8'h25: return 8'h3f; 8'h26: return 8'hf7; 8'h27: return 8'hcc;
      8'h28: return 8'h34; 8'h29: return 8'ha5; 8'h2a: return 8'he5; 8'h2b: return 8'hf1; 8'h2c: return 8'h71; 8'h2d: return 8'hd8; 8'h2e: return 8'h31; 8'h2f: return 8'h15;
      8'h30: return 8'h04; 8'h31: return 8'hc7; 8'h32: return 8'h23; 8'h33: return 8'hc3; 8'h34: return 8'h18; 8'h35: return 8'h96; 8'h36: return 8'h05; 8'h37: return 8'h9a;
      8'h38: return 8'h07; 8'h39: return 8'h12; 8'h3a: return 8'h80; 8'h3b: return 8'he2; 8'h3c: return 8'heb; 8'h3d: return 8'h27; 8'h3e: return 8'hb2; 8'h3f: return 8'h75;
      8'h40: return 8'h09; 8'h41: return 8'h83; 8'h42: return 8'h2c; 8'h43: return 8'h1a; 8'h44: return 8'h1b; 8'h45: return 8'h6e; 8'h46: return 8'h5a; 8'h47: return 8'ha0;
      8'h48: return 8'h52; 8'h49: return 8'h3b; 8'h4a: return 8'hd6; 8'h4b: return 8'hb3; 8'h4c: return 8'h29; 8'h4d: return 8'he3; 8'h4e: return 8'h2f; 8'h4f: return 8'h84;
      8'h50: return 8'h53; 8'h51: return 8'hd1; 8'h52: return 8'h00; 8'h53: return 8'hed; 8'h54: return 8'h20; 8'h55: return 8'hfc; 8'h56: return 8'hb1; 8'h57: return 8'h5b;
      8'h58: return 8'h6a; 8'h59: return 8'hcb; 8'h5a: return 8'hbe; 8'h5b: return 8'h39; 8'h5c: return 8'h4a; 8'h5d: return 8'h4c; 8'h5e: return 8'h58; 8'h5f: return 8'hcf;
      8'h60: return 8'hd0; 8'h61: return 8'hef; 8'h62: return 8'haa; 8'h63: return 8'hfb; 8'h64: return 8'h43; 8'h65: return 8'h4d; 8'h66: return 8'h33; 8'h67: return 8'h85;
      8'h68: return 8'h45; 8'h69: return 8'hf9; 8'h6a: return 8'h02; 8'h6b: return 8'h7f; 8'h6c: return 8'h50; 8'h6d: return 8'h3c; 8'h6e: return 8'h9f; 8'h6f: return 8'ha8;
      8'h70: return 8'h51; 8'h71: return 8'ha3; 8'h72: return 8'h40; 8'h73: return 8'h8f; 8'h74: return 8'h92; 8'h75: return 8'h9d; 8'h76: return 8'h38; 8'h77: return 8'hf5;
      8'h78: return 8'hbc; 8'h79: return 8'hb6; 8'h7a: return 8'hda; 8'h7b: return 8'h21; 8'h7c: return 8'h10; 8'h7d: return 8'hff; 8'h7e: return 8'hf3; 8'h7f: return 8'hd2;
      8'h80: return 8'hcd; 8'h81: return 8'h0c; 8'h82: return 8'h13; 8'h83: return 8'hec; 8'h84: return 8'h5f; 8'h85: return 8'h97; 8'h86: return 8'h44; 8'h87: return 8'h17;
      8'h88: return 8'hc4; 8'h89: return 8'ha7; 8'h8a: return 8'h7e; 8'h8b: return 8'h3d; 8'h8c: return 8'h64; 8'h8d: return 8'h5d; 8'h8e: return 8'h19; 8'h8f: return 8'h73;
      8'h90: return 8'h60; 8'h91: return 8'h81; 8'h92: return 8'h4f; 8'h93: return 8'hdc; 8'h94: return 8'h22; 8'h95: return 8'h2a; 8'h96: return 8'h90; 8'h97: return 8'h88;
      8'h98: return 8'h46; 8'h99: return 8'hee; 8'h9a: return 8'hb8; 8'h9b: return 8'h14; 8'h9c: return 8'hde; 8'h9d: return 8'h5e; 8'h9e: return 8'h0b; 8'h9f: return 8'hdb;
      8'ha0: return 8'he0; 8'ha1: return 8'h32; 8'ha2: return 8'h3a; 8'ha3: return 8'h0a; 8'ha4: return 8'h49; 8'ha5: return 8'h06; 8'ha6: return 8'h24; 8'ha7: return 8'h5c;
      8'ha8: return 8'hc2; 8'ha9: return 8'hd3; 8'haa: return 8'hac; 8'hab: return 8'h62; 8'hac: return 8'h91; 8'had: return 8'h95; 8'hae: return 8'he4; 8'haf: return 8'h79;
      8'hb0: return 8'he7; 8'hb1: return 8'hc8; 8'hb2: return 8'h37; 8'hb3: return 8'h6d; 8'hb4: return 8'h8d; 8'hb5: return 8'hd5; 8'hb6: return 8'h4e; 8'hb7: return 8'ha9;
      8'hb8: return 8'h6c; 8'hb9: return 8'h56; 8'hba: return 8'hf4; 8'hbb: return 8'hea; 8'hbc: return 8'h65; 8'hbd: return 8'h7a; 8'hbe: return 8'hae; 8'hbf: return 8'h08;
      8'hc0: return 8'hba; 8'hc1: return 8'h78; 8'hc2: return 8'h25; 8'hc3: return 8'h2e; 8'hc4: return 8'h1c; 8'hc5: return 8'ha6; 8'hc6: return 8'hb4; 8'hc7: return 8'hc6;
      8'hc8: return 8'he8; 8'hc9: return 8'hdd; 8'hca: return 8'h74; 8'hcb: return 8'h1f; 8'hcc: return 8'h4b; 8'hcd: return 8'hbd; 8'hce: return 8'h8b; 8'hcf: return 8'h8a;
      8'hd0: return 8'h70; 8'hd1: return 8'h3e; 8'hd2: return 8'hb5; 8'hd3: return 8'h66; 8'hd4: return 8'h48; 8'hd5: return 8'h03; 8'hd6: return 8'hf6; 8'hd7: return 8'h0e;
      8'hd8: return 8'h61; 8'hd9: return 8'h35; 8'hda: return 8'h57; 8'hdb: return 8'hb9; 8'hdc: return 8'h86; 8'hdd: return 8'hc1; 8'hde: return 8'h1d; 8'hdf: return 8'h9e;
      8'he0: return 8'he1; 8'he1: return 8'hf8; 8'he2: return 8'h98; 8'he3: return 8'h11; 8'he4: return 8'h69; 8'he5: return 8'hd9; 8'he6: return 8'h8e; 8'he7: return 8'h94;
      8'he8: return 8'h9b; 8'he9: return 8'h1e; 8'hea: return 8'h87; 8'heb: return 8'he9; 8'hec: return 8'hce; 8'hed: return 8'h55; 8'hee: return 8'h28; 8'hef: return 8'hdf;
      8'hf0: return 8'h8c; 8'hf1: return 8'ha1; 8'hf2: return 8'h89; 8'hf3: return 8'h0d; 8'hf4: return 8'hbf; 8'hf5: return 8'he6; 8'hf6: return 8'h42; 8'hf7: return 8'h68;
      8'hf8: return 8'h41; 8'hf9: return 8'h99; 8'hfa: return 8'h2d; 8'hfb: return 8'h0f; 8'hfc: return 8'hb0; 8'hfd: return 8'h54; 8'hfe: return 8'hbb; 8'hff: return 8'h16;
    endcase
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
endpackage

// File: rtl/aes_enc_round.sv
// aes_enc_round: one combinational AES encryption round; i_last_round drops MixColumns.
module aes_enc_round
  import aes192_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic         i_last_round,
  output logic [127:0] o_state
);
  logic [7:0]   w_sb [16];
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  // Byte n sits at row n%4, column n/4; ShiftRows pulls row r from column c+r.
  for (genvar n = 0; n < 16; n++) begin : g_sr
    assign w_sb[n] = sbox(i_state[127-8*n -: 8]);
    assign w_sr[127-8*n -: 8] = w_sb[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)];
  end
  for (genvar c = 0; c < 4; c++) begin : g_mc
    logic [31:0] w_col;
    logic [7:0]  w_sum;
    assign w_col = w_sr[127-32*c -: 32];
    assign w_sum = w_col[31:24] ^ w_col[23:16] ^ w_col[15:8] ^ w_col[7:0];
    for (genvar r = 0; r < 4; r++) begin : g_b
      assign w_mc[127-32*c-8*r -: 8] = w_col[31-8*r -: 8] ^ w_sum ^ xtime(w_col[31-8*r -: 8] ^ w_col[31-8*((r+1)%4) -: 8]);
    end
  end
  assign o_state = (i_last_round ? w_sr : w_mc) ^ i_rk;
endmodule

// File: rtl/aes192_enc.sv
// aes192_enc: iterative AES-192 encryptor, one round per cycle behind ap_ctrl/AXI-stream.
// AES192_ENC_KEY_CACHE_EN: reuse the expanded schedule when the key repeats.
module aes192_enc
  import aes192_pkg::*;
#(
  parameter int NR = 12,
  parameter int NK = 6
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  input  logic         ap_start,
  output logic         ap_done,
  output logic         ap_idle,
  output logic         ap_ready,
  input  logic [127:0] in_r_TDATA,
  input  logic         in_r_TVALID,
  output logic         in_r_TREADY,
  input  logic [191:0] key,
  output logic [127:0] out_r_TDATA,
  output logic         out_r_TVALID,
  input  logic         out_r_TREADY
);
  if (NR != aes192_pkg::NR || NK != aes192_pkg::NK) begin : g_bad_param
    $error("aes192_enc supports only NR=12 and NK=6");
  end
  state_e       r_fsm;
  logic [3:0]   r_cnt;
  logic [127:0] r_state;
  logic [31:0]  r_win [6];
  logic [31:0]  r_rk [48];
  logic [31:0]  w_new [6];
  logic [5:0]   w_idx [6];
  logic [5:0]   w_base;
  logic [127:0] w_rk;
  logic [127:0] w_round;
  logic         w_hs;
  logic         w_hit;
  logic         w_last;
  assign in_r_TREADY  = (r_fsm == IDLE) & ap_start;
  assign ap_idle      = (r_fsm == IDLE) & ~ap_start;
  assign out_r_TVALID = r_fsm == OUT;
  assign out_r_TDATA  = r_state;
  assign ap_done      = out_r_TVALID & out_r_TREADY;
  assign ap_ready     = ap_done;
  assign w_hs         = in_r_TREADY & in_r_TVALID;
  assign w_last       = r_cnt == 4'(NR);
  // r_win is the last six schedule words; group r_cnt+1 extends it by six more.
  always_comb begin
    logic [31:0] v;
    v = sub_word({r_win[5][23:0], r_win[5][31:24]}) ^ {RCON[r_cnt[2:0]], 24'h0};
    for (int k = 0; k < 6; k++) begin
      v = v ^ r_win[k];
      w_new[k] = v;
      w_idx[k] = 6'(6 * r_cnt[2:0] + k + 2);
    end
  end
  // r_rk[m] holds schedule word m+4, so round r uses r_rk[4r-4 .. 4r-1].
  always_comb begin
    w_base = {r_cnt - 4'd1, 2'b00};
    w_rk = {r_rk[w_base], r_rk[w_base + 6'd1], r_rk[w_base + 6'd2], r_rk[w_base + 6'd3]};
  end
  always_ff @(posedge ap_clk) begin
    if (w_hs) begin
      for (int k = 0; k < 6; k++) r_win[k] <= key[191-32*k -: 32];
      r_rk[0] <= key[63:32];
      r_rk[1] <= key[31:0];
    end else if (r_fsm == KEYX) begin
      for (int k = 0; k < 6; k++) begin
        r_win[k] <= w_new[k];
        if (w_idx[k] < 6'd48) r_rk[w_idx[k]] <= w_new[k];
      end
    end
  end
`ifdef AES192_ENC_KEY_CACHE_EN
  logic         r_cache_vld;
  logic [191:0] r_key;
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_cache_vld <= 1'b0;
    else if (r_fsm == KEYX && r_cnt == 4'd7) r_cache_vld <= 1'b1;
  end
  always_ff @(posedge ap_clk) begin
    if (w_hs) r_key <= key;
  end
  assign w_hit = r_cache_vld & (key == r_key);
`else
  assign w_hit = 1'b0;
`endif
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_state <= '0;
    end else begin
      case (r_fsm)
        IDLE: if (w_hs) begin
          r_state <= in_r_TDATA ^ key[191:64];
          r_fsm   <= w_hit ? ROUND : KEYX;
          r_cnt   <= w_hit ? 4'd1 : 4'd0;
        end
        KEYX: begin
          r_fsm <= r_cnt == 4'd7 ? ROUND : KEYX;
          r_cnt <= r_cnt == 4'd7 ? 4'd1 : r_cnt + 4'd1;
        end
        ROUND: begin
          r_state <= w_round;
          r_fsm   <= w_last ? OUT : ROUND;
          r_cnt   <= w_last ? 4'd0 : r_cnt + 4'd1;
        end
        default: if (out_r_TREADY) r_fsm <= IDLE;
      endcase
    end
  end
  aes_enc_round u_round (
    .i_state      (r_state),
    .i_rk         (w_rk),
    .i_last_round (w_last),
    .o_state      (w_round)
  );
endmodule

// File: tb/tb_aes192_enc.sv
// tb_aes192_enc: scoreboard bench for aes192_enc using FIPS-197 and SP800-38A vectors.
module tb_aes192_enc;
  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic         ap_start = 1'b0;
  logic         ap_done, ap_idle, ap_ready;
  logic [127:0] in_r_TDATA = '0;
  logic         in_r_TVALID = 1'b0;
  logic         in_r_TREADY;
  logic [191:0] key = '0;
  logic [127:0] out_r_TDATA;
  logic         out_r_TVALID;
  logic         out_r_TREADY = 1'b1;
  int           n_chk = 0;
  int           n_err = 0;
  logic [127:0] sb [$];
  logic [191:0] last_key = '0;
  bit           have_key = 1'b0;
`ifdef AES192_ENC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam logic [191:0] K_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] P_C2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [191:0] K_N  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] P_N1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C_N1 = 128'hbd334f1d6e45f25ff712a214571fa5cc;
  localparam logic [127:0] P_N2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C_N2 = 128'h974104846d0ad3ad7734ecb3ecee4eef;
  aes192_enc dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .in_r_TDATA   (in_r_TDATA),
    .in_r_TVALID  (in_r_TVALID),
    .in_r_TREADY  (in_r_TREADY),
    .key          (key),
    .out_r_TDATA  (out_r_TDATA),
    .out_r_TVALID (out_r_TVALID),
    .out_r_TREADY (out_r_TREADY)
  );
  always #5 ap_clk = ~ap_clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // Called at a negedge; returns at a negedge. kchg/rst_at are cycle offsets after the handshake (0 = unused).
  task automatic run_block(input logic [191:0] k, input logic [127:0] pt, input logic [127:0] ct,
                           input int stall, input int kchg, input int rst_at);
    int           lat;
    int           n;
    logic [127:0] hold;
    logic [127:0] exp_ct;
    lat = (CACHE && have_key && k == last_key) ? 13 : 21;
    ap_start = 1'b1;
    in_r_TVALID = 1'b1;
    in_r_TDATA = pt;
    key = k;
    out_r_TREADY = stall == 0;
    #1;
    chk("in_ready_at_start", in_r_TREADY, 1);
    chk("busy_not_idle", ap_idle, 0);
    sb.push_back(ct);
    @(negedge ap_clk);
    ap_start = 1'b0;
    in_r_TVALID = 1'b0;
    in_r_TDATA = '0;
    last_key = k;
    have_key = 1'b1;
    for (n = 1; n <= 40; n++) begin
      if (n == kchg) key = '1;
      if (n == rst_at) begin
        ap_rst = 1'b1;
        #1;
        chk("rst_valid", out_r_TVALID, 0);
        chk("rst_idle", ap_idle, 1);
        @(negedge ap_clk);
        chk("rst_hold_valid", out_r_TVALID, 0);
        ap_rst = 1'b0;
        sb.delete();
        have_key = 1'b0;
        return;
      end
      if (out_r_TVALID) break;
      @(negedge ap_clk);
    end
    if (!out_r_TVALID) begin
      chk("valid_timeout", out_r_TVALID, 1);
      void'(sb.pop_front());
      return;
    end
    chk("latency", n, lat);
    hold = out_r_TDATA;
    for (int s = 0; s < stall; s++) begin
      ap_start = 1'b1;
      #1;
      chk("stall_valid", out_r_TVALID, 1);
      chk("stall_data", out_r_TDATA, hold);
      chk("stall_done", ap_done, 0);
      chk("stall_in_ready", in_r_TREADY, 0);
      @(negedge ap_clk);
    end
    ap_start = 1'b0;
    out_r_TREADY = 1'b1;
    #1;
    exp_ct = sb.size() > 0 ? sb.pop_front() : 'x;
    chk("ap_done", ap_done, 1);
    chk("ap_ready", ap_ready, 1);
    chk("ciphertext", out_r_TDATA, exp_ct);
    @(negedge ap_clk);
    chk("done_pulse", ap_done, 0);
    chk("back_idle", ap_idle, 1);
    chk("valid_drop", out_r_TVALID, 0);
  endtask
  initial begin
    @(negedge ap_clk);
    #1;
    chk("rst_out_valid", out_r_TVALID, 0);
    chk("rst_in_ready", in_r_TREADY, 0);
    chk("rst_done", ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_tdata", out_r_TDATA, 0);
    chk("rst_ap_idle", ap_idle, 1);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    run_block(K_C2, P_C2, C_C2, 0, 0, 0);
    run_block(K_C2, P_C2, C_C2, 0, 0, 0);
    run_block(K_N, P_N1, C_N1, 10, 0, 0);
    run_block(K_N, P_N2, C_N2, 0, 0, 0);
    in_r_TVALID = 1'b1;
    in_r_TDATA = P_C2;
    key = K_C2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("nostart_in_ready", in_r_TREADY, 0);
      chk("nostart_idle", ap_idle, 1);
      @(negedge ap_clk);
    end
    run_block(K_C2, P_C2, C_C2, 0, 0, 0);
    run_block(K_C2, P_C2, C_C2, 0, 3, 0);
    run_block(K_C2, P_C2, C_C2, 0, 0, 12);
    @(negedge ap_clk);
    run_block(K_C2, P_C2, C_C2, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
